md_issue_ctrl: RTL and testbench

//  Initiator side of the hi/lo multiply-divide interface. Sits in the D/E stage boundary.
//  - Accepts decoded md ops and issues them to the md engine with a req/ack handshake.
//  - Tracks the outstanding op until the engine's done pulse; stalls the pipeline on md hazards.
//  - Cancels un-acked issues on flush.

---
 rtl/md_pkg.sv | 34 +++
 rtl/md_tmo_timer.sv | 33 +++
 rtl/md_issue_ctrl.sv | 118 +++++++++++
 tb/tb_md_issue_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared op codes, op-class decode and FSM state encoding for the hi/lo md issue logic.
package md_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MTLO  = 4'd1;
    localparam logic [3:0] MD_MTHI  = 4'd2;
    localparam logic [3:0] MD_DIVU  = 4'd3;
    localparam logic [3:0] MD_DIV   = 4'd4;
    localparam logic [3:0] MD_MULTU = 4'd5;
    localparam logic [3:0] MD_MULT  = 4'd6;
    localparam logic [3:0] MD_MFLO  = 4'd7;
    localparam logic [3:0] MD_MFHI  = 4'd8;
    localparam logic [3:0] MD_MADD  = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } md_state_e;

    // Codes 10..15 fall through every class and so behave as no-op.
    function automatic logic is_long(input logic [3:0] op);
        return op inside {MD_DIVU, MD_DIV, MD_MULTU, MD_MULT, MD_MADD};
    endfunction

    function automatic logic is_set(input logic [3:0] op);
        return op inside {MD_MTLO, MD_MTHI};
    endfunction

    function automatic logic is_read(input logic [3:0] op);
        return op inside {MD_MFLO, MD_MFHI};
    endfunction

endpackage

// File: rtl/md_tmo_timer.sv
// Saturating 8-bit wait timer; hit is high while the count equals TMO_CYC.
module md_tmo_timer #(
    parameter int TMO_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && cnt_q != 8'hff) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == 8'(TMO_CYC));

endmodule

// File: rtl/md_issue_ctrl.sv
// Issues decoded hi/lo md ops to the md engine, tracks them to completion and stalls D on hazards.
// Optional stall-cycle perf counter is built when MD_PERF_CNT_EN is defined.
module md_issue_ctrl #(
    parameter int OPW     = 4,
    parameter int TMO_CYC = 16,
    parameter int CNTW    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_d,
    input  logic [OPW-1:0]  op_d,
    input  logic            flush,
    output logic            md_req,
    output logic [OPW-1:0]  md_op,
    input  logic            md_ack,
    input  logic            md_done,
    output logic            rd_en,
    output logic            rd_hi,
    output logic            md_stall,
    output logic            md_err,
    output logic [CNTW-1:0] stall_cnt,
    output logic [1:0]      dbg_state
);
    import md_pkg::*;

    md_state_e      state_q, state_d;
    logic [OPW-1:0] md_op_q, md_op_d;
    logic           md_err_q, md_err_d;
    logic           tmo_hit;
    logic           op_ok;
    logic [3:0]     op_lo;

    // Any op bits above the 4-bit code space turn the op into a no-op.
    assign op_ok = ((op_d >> 4) == '0);
    assign op_lo = op_d[3:0];

    // Handshake: md_req is a valid that stays high with md_op stable until the cycle
    // md_ack is seen; that cycle is the transfer. Only flush may withdraw an unacked req.
    always_comb begin
        state_d = state_q;
        md_op_d = md_op_q;
        unique case (state_q)
            IDLE: begin
                if (valid_d && op_ok && (is_long(op_lo) || is_set(op_lo))) begin
                    state_d = REQ;
                    md_op_d = op_d;
                end
            end
            REQ: begin
                if (md_ack) begin
                    state_d = is_set(md_op_q[3:0]) ? IDLE : BUSY;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (md_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    md_tmo_timer #(
        .TMO_CYC(TMO_CYC)
    ) u_tmo (
        .clk  (clk),
        .reset(reset),
        .clr  (state_d != state_q),
        .en   (state_q != IDLE),
        .hit  (tmo_hit)
    );

    assign md_err_d = md_err_q | tmo_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            md_op_q  <= '0;
            md_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            md_op_q  <= md_op_d;
            md_err_q <= md_err_d;
        end
    end

    assign md_req    = (state_q == REQ);
    assign md_op     = md_op_q;
    assign md_err    = md_err_q | tmo_hit;
    assign dbg_state = state_q;
    assign md_stall  = valid_d && op_ok && (is_long(op_lo) || is_set(op_lo) || is_read(op_lo))
                       && (state_q != IDLE);
    assign rd_en     = valid_d && op_ok && is_read(op_lo) && (state_q == IDLE);
    assign rd_hi     = op_ok && (op_lo == MD_MFHI);

`ifdef MD_PERF_CNT_EN
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + CNTW'(md_stall);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Table-driven bench for md_issue_ctrl with an expected-value queue per cycle.
module tb_md_issue_ctrl;

    localparam int OPW     = 4;
    localparam int TMO_CYC = 16;
    localparam int CNTW    = 32;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_BUSY = 2'd2;

    logic            clk = 1'b0;
    logic            reset;
    logic            valid_d;
    logic [OPW-1:0]  op_d;
    logic            flush;
    logic            md_req;
    logic [OPW-1:0]  md_op;
    logic            md_ack;
    logic            md_done;
    logic            rd_en;
    logic            rd_hi;
    logic            md_stall;
    logic            md_err;
    logic [CNTW-1:0] stall_cnt;
    logic [1:0]      dbg_state;

    md_issue_ctrl #(
        .OPW(OPW), .TMO_CYC(TMO_CYC), .CNTW(CNTW)
    ) dut (
        .clk(clk), .reset(reset), .valid_d(valid_d), .op_d(op_d), .flush(flush),
        .md_req(md_req), .md_op(md_op), .md_ack(md_ack), .md_done(md_done),
        .rd_en(rd_en), .rd_hi(rd_hi), .md_stall(md_stall), .md_err(md_err),
        .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       v;
        logic [3:0] op;
        logic       fl;
        logic       ack;
        logic       done;
        logic       req;
        logic [3:0] mop;
        logic       rd;
        logic       hi;
        logic       st;
        logic       err;
        logic [1:0] s;
    } vec_t;

    vec_t        tbl[$];
    logic [10:0] exp_q[$];
    int          n_checks   = 0;
    int          n_fail     = 0;
    int          exp_stalls = 0;

    function automatic vec_t mk(input logic v, input logic [3:0] op, input logic fl,
                                input logic ack, input logic done, input logic req,
                                input logic [3:0] mop, input logic rd, input logic hi,
                                input logic st, input logic err, input logic [1:0] s);
        vec_t t;
        t.v = v; t.op = op; t.fl = fl; t.ack = ack; t.done = done;
        t.req = req; t.mop = mop; t.rd = rd; t.hi = hi; t.st = st; t.err = err; t.s = s;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // driver: one cycle of stimulus, expected word queued, compared at negedge
    task automatic apply(input vec_t t, input string name);
        logic [10:0] exp_w;
        logic [10:0] act_w;
        valid_d = t.v; op_d = t.op; flush = t.fl; md_ack = t.ack; md_done = t.done;
        exp_q.push_back({t.req, t.mop, t.rd, t.hi, t.st, t.err, t.s});
        if (t.st) exp_stalls++;
        @(negedge clk);
        act_w = {md_req, md_op, rd_en, rd_hi, md_stall, md_err, dbg_state};
        exp_w = exp_q.pop_front();
        check(name, 32'(act_w), 32'(exp_w));
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   32'(md_req),    32'd0);
        check({tag, "_op"},    32'(md_op),     32'd0);
        check({tag, "_rd"},    32'({rd_en, rd_hi}), 32'd0);
        check({tag, "_stall"}, 32'(md_stall),  32'd0);
        check({tag, "_err"},   32'(md_err),    32'd0);
        check({tag, "_cnt"},   stall_cnt,      32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    endtask

    initial begin
        reset = 1'b1; valid_d = 1'b0; op_d = '0; flush = 1'b0; md_ack = 1'b0; md_done = 1'b0;

        // cols: v op fl ack done | req mop rd hi st err state
        // test 1: mult, ack, done later; mfhi waits out BUSY
        tbl.push_back(mk(1, 6, 0, 0, 0,  0, 0, 0, 0, 0, 0, S_IDLE));
        tbl.push_back(mk(0, 0, 0, 1, 0,  1, 6, 0, 0, 0, 0, S_REQ));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 6, 0, 0, 0, 0, S_BUSY));
        tbl.push_back(mk(1, 8, 0, 0, 0,  0, 6, 0, 1, 1, 0, S_BUSY));
        tbl.push_back(mk(1, 8, 0, 0, 0,  0, 6, 0, 1, 1, 0, S_BUSY));
        tbl.push_back(mk(1, 8, 0, 0, 0,  0, 6, 0, 1, 1, 0, S_BUSY));
        tbl.push_back(mk(1, 8, 0, 0, 1,  0, 6, 0, 1, 1, 0, S_BUSY));
        tbl.push_back(mk(1, 8, 0, 0, 0,  0, 6, 1, 1, 0, 0, S_IDLE));
        // test 2: mtlo with immediate ack; mflo stalls in REQ then reads
        tbl.push_back(mk(1, 1, 0, 0, 0,  0, 6, 0, 0, 0, 0, S_IDLE));
        tbl.push_back(mk(1, 7, 0, 1, 0,  1, 1, 0, 0, 1, 0, S_REQ));
        tbl.push_back(mk(1, 7, 0, 0, 0,  0, 1, 1, 0, 0, 0, S_IDLE));
        // done/ack outside their states, invalid read, undefined code
        tbl.push_back(mk(0, 7, 0, 0, 1,  0, 1, 0, 0, 0, 0, S_IDLE));
        tbl.push_back(mk(1, 12, 0, 1, 0, 0, 1, 0, 0, 0, 0, S_IDLE));
        // test 3: div without ack, flushed; multu then issues normally
        tbl.push_back(mk(1, 4, 0, 0, 0,  0, 1, 0, 0, 0, 0, S_IDLE));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1, 4, 0, 0, 0, 0, S_REQ));
        tbl.push_back(mk(0, 0, 1, 0, 0,  1, 4, 0, 0, 0, 0, S_REQ));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 4, 0, 0, 0, 0, S_IDLE));
        tbl.push_back(mk(1, 5, 0, 0, 0,  0, 4, 0, 0, 0, 0, S_IDLE));
        tbl.push_back(mk(0, 0, 0, 1, 0,  1, 5, 0, 0, 0, 0, S_REQ));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 5, 0, 0, 0, 0, S_BUSY));
        tbl.push_back(mk(0, 0, 0, 0, 1,  0, 5, 0, 0, 0, 0, S_BUSY));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 5, 0, 0, 0, 0, S_IDLE));
        // test 4: divu with flush+ack together; flush ignored in BUSY
        tbl.push_back(mk(1, 3, 0, 0, 0,  0, 5, 0, 0, 0, 0, S_IDLE));
        tbl.push_back(mk(0, 0, 1, 1, 0,  1, 3, 0, 0, 0, 0, S_REQ));
        tbl.push_back(mk(1, 13, 1, 0, 0, 0, 3, 0, 0, 0, 0, S_BUSY));
        tbl.push_back(mk(1, 2, 1, 0, 0,  0, 3, 0, 0, 1, 0, S_BUSY));
        tbl.push_back(mk(0, 0, 0, 0, 1,  0, 3, 0, 0, 0, 0, S_BUSY));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 3, 0, 0, 0, 0, S_IDLE));

        #12;
        check_all_zero("reset_hold");
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec[%0d]", i));
        end

        // test 5: madd acked, done withheld past the timeout; md_err sticks
        apply(mk(1, 9, 0, 0, 0, 0, 3, 0, 0, 0, 0, S_IDLE), "tmo_issue");
        apply(mk(0, 0, 0, 1, 0, 1, 9, 0, 0, 0, 0, S_REQ), "tmo_ack");
        for (int k = 0; k < 20; k++) begin
            apply(mk(0, 0, 0, 0, 0, 0, 9, 0, 0, 0, (k >= TMO_CYC), S_BUSY),
                  $sformatf("tmo_wait[%0d]", k));
        end
        apply(mk(0, 0, 0, 0, 1, 0, 9, 0, 0, 0, 1, S_BUSY), "tmo_done");
        apply(mk(0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 1, S_IDLE), "tmo_after");

        // test 6: reset asserted mid-BUSY between clock edges
        apply(mk(1, 6, 0, 0, 0, 0, 9, 0, 0, 0, 1, S_IDLE), "rst_issue");
        apply(mk(0, 0, 0, 1, 0, 1, 6, 0, 0, 0, 1, S_REQ), "rst_ack");
        for (int k = 0; k < 3; k++) begin
            apply(mk(1, 7, 0, 0, 0, 0, 6, 0, 0, 1, 1, S_BUSY), $sformatf("rst_stall[%0d]", k));
        end
`ifdef MD_PERF_CNT_EN
        check("stall_cnt", stall_cnt, 32'(exp_stalls));
`else
        check("stall_cnt", stall_cnt, 32'd0);
`endif
        md_ack = 1'b0; md_done = 1'b0; flush = 1'b0; valid_d = 1'b0; op_d = '0;
        reset = 1'b1;
        #2;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        reset = 1'b0;

        apply(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_IDLE), "post_rst_issue");
        apply(mk(0, 0, 0, 1, 0, 1, 5, 0, 0, 0, 0, S_REQ), "post_rst_ack");
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
